emin_dp_update: RTL and testbench

// - Consumes the Emin(j,i) stream produced by the emin stage and runs the segmentation DP step:
//   D(i) = min over j in 0..i of ( D(j-1) + Emin(j,i) ), with D(-1) = 0.
// - Keeps D(i) and the backpointer B(i) = argmin j in internal memories.
// - Reports each D(i) downstream and exposes B() through a read port for traceback.
// - Sits directly downstream of emin; i_in/i_valid_in are driven in parallel with emin's i/input_valid.

---
 rtl/emin_dp_update_pkg.sv | 21 ++
 rtl/emin_dp_update_sat_add.sv | 26 ++
 rtl/emin_dp_update.sv | 181 ++++++++++++++++++
 tb/tb_emin_dp_update.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emin_dp_update_pkg.sv
// Shared types and helpers for the Emin segmentation DP update stage.
package emin_dp_pkg;

    // Control states of the DP update sequencer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } dp_state_t;

    // Largest representable signed cost for a given word width.
    function automatic longint cost_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest representable signed cost for a given word width.
    function automatic longint cost_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/emin_dp_update_sat_add.sv
// Combinational saturating signed adder: the sum is formed one bit wider and
// clamped to the signed range of WIDTH bits on overflow.
module sat_add_signed #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] wide;

    // Widened add, then clamp when the two top bits disagree (overflow).
    always_comb begin
        wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (wide[WIDTH] != wide[WIDTH-1]) begin
            sum = wide[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/emin_dp_update.sv
// Segmentation DP step: D(i) = min_j ( D(j-1) + Emin(j,i) ), D(-1) = 0.
// Consumes the Emin(j,i) stream for one i at a time, keeps D() and the
// backpointer B() in block RAM, reports each D(i) and offers B() for traceback.
module emin_dp_update
    import emin_dp_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    localparam int IW       = $clog2(I)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 frame_start_in,
    input  logic [IW-1:0]        i_in,
    input  logic                 i_valid_in,
    input  logic [IW-1:0]        emin_j_in,
    input  logic [BIT_WIDTH-1:0] emin_in,
    input  logic                 emin_valid_in,
    output logic [BIT_WIDTH-1:0] cost_out,
    output logic [IW-1:0]        bp_out,
    output logic [IW-1:0]        i_out,
    output logic                 result_valid_out,
    output logic                 seq_error_out,
    input  logic [IW-1:0]        bp_addr_in,
    output logic [IW-1:0]        bp_data_out
);

    localparam logic signed [BIT_WIDTH-1:0] COST_MAX = BIT_WIDTH'(cost_max(BIT_WIDTH));

    // Sequencer state and the index currently being solved.
    dp_state_t                   state_reg;
    logic [IW-1:0]               i_reg;
    logic [IW-1:0]               exp_i_reg;

    // Running minimum for the current i.
    logic signed [BIT_WIDTH-1:0] best_reg;
    logic [IW-1:0]               best_j_reg;

    // S1 pipeline registers: sample j, its Emin, and whether D(j-1) is D(-1).
    logic                        s1_valid_reg;
    logic [IW-1:0]               s1_j_reg;
    logic signed [BIT_WIDTH-1:0] s1_emin_reg;
    logic                        s1_jzero_reg;

    // D and B memories (one write port, one registered read port each).
    logic signed [BIT_WIDTH-1:0] d_mem [0:I-1];
    logic [IW-1:0]               b_mem [0:I-1];
    logic signed [BIT_WIDTH-1:0] d_rd_data_reg;

    // Combinational helpers.
    logic                        accept_sample;
    logic                        last_sample;
    logic [IW-1:0]               d_rd_addr;
    logic signed [BIT_WIDTH-1:0] dprev;
    logic signed [BIT_WIDTH-1:0] cand;
    logic                        wr_en;
    logic [IW-1:0]               exp_now;

    // Sample qualification, D read address, S2 operand and write-back strobe.
    always_comb begin
        accept_sample = (state_reg == ACCUM) && emin_valid_in && !frame_start_in
                        && (emin_j_in <= i_reg);
        last_sample   = accept_sample && (emin_j_in == i_reg);
        d_rd_addr     = (emin_j_in != '0) ? (emin_j_in - 1'b1) : '0;
        dprev         = s1_jzero_reg ? '0 : d_rd_data_reg;
        wr_en         = (state_reg == FLUSH) && !s1_valid_reg && !rst_in;
        exp_now       = frame_start_in ? '0 : exp_i_reg;
    end

    sat_add_signed #(
        .WIDTH (BIT_WIDTH)
    ) u_sat_add (
        .a   (dprev),
        .b   (s1_emin_reg),
        .sum (cand)
    );

    // D memory: write-back of D(i); the read is captured on the S1 edge.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            d_mem[i_reg] <= best_reg;
        end
        d_rd_data_reg <= d_mem[d_rd_addr];
    end

    // B memory: write-back of B(i).
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            b_mem[i_reg] <= best_j_reg;
        end
    end

    // Traceback read port, independent of the sequencer; one-cycle latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bp_data_out <= '0;
        end else begin
            bp_data_out <= b_mem[bp_addr_in];
        end
    end

    // Sequencer with S1/S2 pipeline, running minimum and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg        <= IDLE;
            i_reg            <= '0;
            exp_i_reg        <= '0;
            best_reg         <= '0;
            best_j_reg       <= '0;
            s1_valid_reg     <= 1'b0;
            s1_j_reg         <= '0;
            s1_emin_reg      <= '0;
            s1_jzero_reg     <= 1'b0;
            cost_out         <= '0;
            bp_out           <= '0;
            i_out            <= '0;
            result_valid_out <= 1'b0;
            seq_error_out    <= 1'b0;
        end else begin
            result_valid_out <= 1'b0;
            seq_error_out    <= 1'b0;

            // S1: capture accepted sample alongside the D(j-1) read.
            s1_valid_reg <= accept_sample;
            if (accept_sample) begin
                s1_j_reg     <= emin_j_in;
                s1_emin_reg  <= $signed(emin_in);
                s1_jzero_reg <= (emin_j_in == '0);
            end

            // S2: fold candidate; strict compare keeps the earlier j on ties.
            if (s1_valid_reg && (cand < best_reg)) begin
                best_reg   <= cand;
                best_j_reg <= s1_j_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (i_valid_in) begin
                        i_reg      <= i_in;
                        best_reg   <= COST_MAX;
                        best_j_reg <= '0;
                        exp_i_reg  <= i_in + 1'b1;
                        state_reg  <= ACCUM;
                        if (i_in != exp_now) begin
                            seq_error_out <= 1'b1;
                        end
                    end else if (frame_start_in) begin
                        exp_i_reg <= '0;
                    end
                end
                ACCUM: begin
                    if (frame_start_in) begin
                        // Abort: the in-flight S1 sample is discarded above.
                        exp_i_reg <= '0;
                        state_reg <= IDLE;
                    end else if (last_sample) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (frame_start_in) begin
                        exp_i_reg <= '0;
                    end
                    // Once S2 has folded j == i, commit and report.
                    if (!s1_valid_reg) begin
                        cost_out         <= best_reg;
                        bp_out           <= best_j_reg;
                        i_out            <= i_reg;
                        result_valid_out <= 1'b1;
                        state_reg        <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emin_dp_update.sv
// Randomised self-checking bench for emin_dp_update against a behavioural
// DP model (arrays of D and B, saturating arithmetic in 64-bit integers).
module tb_emin_dp_update;

    localparam int BW = 32;
    localparam int I  = 160;
    localparam int IW = $clog2(I);
    localparam longint CMAX = (longint'(1) <<< (BW - 1)) - 1;
    localparam longint CMIN = -(longint'(1) <<< (BW - 1));

    logic          clk;
    logic          rst_in;
    logic          frame_start_in;
    logic [IW-1:0] i_in;
    logic          i_valid_in;
    logic [IW-1:0] emin_j_in;
    logic [BW-1:0] emin_in;
    logic          emin_valid_in;
    logic [BW-1:0] cost_out;
    logic [IW-1:0] bp_out;
    logic [IW-1:0] i_out;
    logic          result_valid_out;
    logic          seq_error_out;
    logic [IW-1:0] bp_addr_in;
    logic [IW-1:0] bp_data_out;

    emin_dp_update #(.BIT_WIDTH(BW), .I(I)) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .i_in             (i_in),
        .i_valid_in       (i_valid_in),
        .emin_j_in        (emin_j_in),
        .emin_in          (emin_in),
        .emin_valid_in    (emin_valid_in),
        .cost_out         (cost_out),
        .bp_out           (bp_out),
        .i_out            (i_out),
        .result_valid_out (result_valid_out),
        .seq_error_out    (seq_error_out),
        .bp_addr_in       (bp_addr_in),
        .bp_data_out      (bp_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seq_cnt = 0;
    int exp_model = 0;

    longint rq_cost[$];
    int     rq_bp[$];
    int     rq_i[$];
    int     rq_cyc[$];

    longint d_model [I];
    int     b_model [I];
    longint em_buf  [I];

    always @(posedge clk) cyc <= cyc + 1;

    // Result and sequence-error monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (result_valid_out) begin
            rq_cost.push_back(longint'($signed(cost_out)));
            rq_bp.push_back(int'(bp_out));
            rq_i.push_back(int'(i_out));
            rq_cyc.push_back(cyc);
        end
        if (seq_error_out) seq_cnt = seq_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat(input longint v);
        if (v > CMAX) return CMAX;
        if (v < CMIN) return CMIN;
        return v;
    endfunction

    function automatic longint rand_emin();
        int unsigned m;
        m = $urandom_range(0, 3);
        case (m)
            0:       return longint'($urandom_range(0, 40)) - 20;
            1:       return longint'($signed($urandom));
            2:       return CMAX - longint'($urandom_range(0, 50));
            default: return CMIN + longint'($urandom_range(0, 50));
        endcase
    endfunction

    task automatic idle_inputs();
        frame_start_in = 1'b0;
        i_valid_in     = 1'b0;
        emin_valid_in  = 1'b0;
        emin_j_in      = '0;
        emin_in        = '0;
    endtask

    // One full i transaction using em_buf[0..i]; checks result against model.
    task automatic run_i(input int i, input bit fs, input bit noisy);
        int     sc;
        int     base_seq;
        int     bj;
        int     seq_exp;
        longint best;
        longint c;
        longint dp;
        seq_exp   = (i != (fs ? 0 : exp_model)) ? 1 : 0;
        exp_model = i + 1;
        base_seq  = seq_cnt;
        frame_start_in = fs;
        i_valid_in     = 1'b1;
        i_in           = IW'(i);
        tick();
        idle_inputs();
        for (int j = 0; j <= i; j++) begin
            if (noisy) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    emin_valid_in = (i < I - 1);
                    emin_j_in     = (i < I - 1) ? IW'($urandom_range(i + 1, I - 1)) : '0;
                    emin_in       = $urandom;
                    i_valid_in    = 1'($urandom_range(0, 1));
                    i_in          = IW'($urandom_range(0, I - 1));
                    tick();
                end
                idle_inputs();
            end
            emin_valid_in = 1'b1;
            emin_j_in     = IW'(j);
            emin_in       = em_buf[j][BW-1:0];
            tick();
        end
        sc = cyc;
        if (noisy) begin
            emin_j_in = IW'($urandom_range(0, i));
            emin_in   = $urandom;
            tick();
        end
        idle_inputs();
        best = CMAX;
        bj   = 0;
        for (int j = 0; j <= i; j++) begin
            dp = (j == 0) ? 0 : d_model[j-1];
            c  = sat(dp + em_buf[j]);
            if (c < best) begin
                best = c;
                bj   = j;
            end
        end
        d_model[i] = best;
        b_model[i] = bj;
        for (int k = 0; k < 30 && rq_cost.size() == 0; k++) tick();
        if (rq_cost.size() == 0) begin
            check("result_timeout", 0, 1);
        end else begin
            check("cost_out", rq_cost[0], best);
            check("bp_out", rq_bp[0], bj);
            check("i_out", rq_i[0], i);
            check("latency", rq_cyc[0] - sc, 2);
            $display("txn i=%0d fs=%0d cost=%0d bp=%0d exp_cost=%0d exp_bp=%0d",
                     i, fs, rq_cost[0], rq_bp[0], best, bj);
            void'(rq_cost.pop_front());
            void'(rq_bp.pop_front());
            void'(rq_i.pop_front());
            void'(rq_cyc.pop_front());
        end
        check("seq_error", seq_cnt - base_seq, seq_exp);
        check("extra_results", rq_cost.size(), 0);
    endtask

    // i=4 stream interrupted after j=1 by frame start or reset.
    task automatic abort_i4(input bit use_rst);
        i_valid_in = 1'b1;
        i_in       = IW'(4);
        tick();
        idle_inputs();
        for (int j = 0; j < 2; j++) begin
            emin_valid_in = 1'b1;
            emin_j_in     = IW'(j);
            emin_in       = $urandom;
            tick();
        end
        idle_inputs();
        if (use_rst) begin
            rst_in = 1'b1;
            tick();
            tick();
            check("rst_bp_data", bp_data_out, 0);
            check("rst_valid", result_valid_out, 0);
            rst_in = 1'b0;
        end else begin
            frame_start_in = 1'b1;
            tick();
            frame_start_in = 1'b0;
        end
        exp_model = 0;
        for (int j = 2; j <= 4; j++) begin
            emin_valid_in = 1'b1;
            emin_j_in     = IW'(j);
            emin_in       = $urandom;
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 10; k++) tick();
        check("abort_no_result", rq_cost.size(), 0);
        if (use_rst) begin
            check("rst_cost", cost_out, 0);
            check("rst_bp", bp_out, 0);
            check("rst_i", i_out, 0);
        end
        $display("txn abort i=4 by %s", use_rst ? "reset" : "frame_start");
        rq_cost.delete();
        rq_bp.delete();
        rq_i.delete();
        rq_cyc.delete();
    endtask

    initial begin
        rst_in     = 1'b1;
        bp_addr_in = '0;
        i_in       = '0;
        idle_inputs();
        repeat (3) tick();
        check("reset_cost", cost_out, 0);
        check("reset_bp", bp_out, 0);
        check("reset_i", i_out, 0);
        check("reset_valid", result_valid_out, 0);
        check("reset_seq", seq_error_out, 0);
        check("reset_bp_data", bp_data_out, 0);
        rst_in = 1'b0;
        tick();

        // Directed DP steps, including the tie case.
        em_buf[0] = 5;                                   run_i(0, 0, 0);
        em_buf[0] = 10; em_buf[1] = 2;                   run_i(1, 0, 0);
        em_buf[0] = 12; em_buf[1] = 7; em_buf[2] = 5;    run_i(2, 0, 0);
        bp_addr_in = IW'(1);
        tick();
        check("bp_read_1", bp_data_out, b_model[1]);
        bp_addr_in = IW'(2);
        tick();
        check("bp_read_2", bp_data_out, b_model[2]);

        // Out-of-order i flags an error; frame start restarts at 0.
        for (int j = 0; j < 2; j++) em_buf[j] = rand_emin();
        run_i(1, 0, 0);
        em_buf[0] = 3;
        run_i(0, 1, 0);

        // Saturation at both ends.
        em_buf[0] = CMAX - 1;                            run_i(0, 1, 0);
        em_buf[0] = CMAX; em_buf[1] = 10;                run_i(1, 0, 0);
        em_buf[0] = CMIN; em_buf[1] = CMIN; em_buf[2] = 3; run_i(2, 0, 0);
        em_buf[0] = -1; em_buf[1] = CMIN; em_buf[2] = 0; em_buf[3] = -7;
        run_i(3, 0, 0);

        abort_i4(0);

        // Full random frame, noisy on a subset of indices.
        for (int i = 0; i < I; i++) begin
            for (int j = 0; j <= i; j++) em_buf[j] = rand_emin();
            run_i(i, (i == 0), (i < 20) || (i % 7 == 0));
        end
        for (int k = 0; k < 4; k++) begin
            int a;
            a = $urandom_range(0, I - 1);
            bp_addr_in = IW'(a);
            tick();
            check("bp_read_rand", bp_data_out, b_model[a]);
        end

        abort_i4(1);

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j <= i; j++) em_buf[j] = rand_emin();
            run_i(i, (i == 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
